program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256: the largest accepted word count.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port rx_valid, input, 1 bit: the host byte on rx_data is valid.
REQ-006 Port rx_data, input, 8 bits: host byte.
REQ-007 Port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-008 Port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 Port imem_addr, output, 32 bits: instruction-memory byte address.
REQ-010 Port imem_wdata, output, 32 bits: instruction word to write.
REQ-011 Port cpu_reset_n, output, 1 bit: active-low reset to the processor (PC, register file).
REQ-012 Port done, output, 1 bit: the load completed with a good checksum.
REQ-013 Port error, output, 1 bit: the load was aborted.
REQ-014 Port words_loaded, output, 16 bits: count of words written so far.

Function
REQ-015 A byte SHALL be accepted on a rising clk edge when rx_valid=1 and rx_ready=1; no other byte SHALL be consumed.
REQ-016 States: WAIT_SYNC, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR.
REQ-017 rx_ready SHALL be 1 in WAIT_SYNC, CNT_HI, CNT_LO, DATA and CHECK, and 0 in DONE and ERROR.
REQ-018 In WAIT_SYNC, an accepted byte 8'hA5 SHALL move the block to CNT_HI; any other accepted byte SHALL be discarded and the block SHALL stay in WAIT_SYNC.
REQ-019 CNT_HI and CNT_LO SHALL capture the 16-bit word count big-endian, then transition as follows:
- count=0 -> CHECK;
- count>MAX_WORDS -> ERROR;
- otherwise -> DATA.
REQ-020 In DATA, bytes SHALL be assembled big-endian, 4 per word, with a 2-bit byte counter.
REQ-021 On acceptance of the 4th byte of a word, in the following cycle the block SHALL:
- assert imem_we for exactly 1 cycle;
- drive imem_addr = BASE_ADDR + 4*index and imem_wdata = the assembled word;
- increment words_loaded.
REQ-022 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-023 Acceptance of the 4th byte of the last word SHALL move the block to CHECK.
REQ-024 A byte accepted in the same cycle as an imem_we pulse SHALL NOT be lost; assembly of the next word continues.
REQ-025 The checksum SHALL be the 8-bit sum modulo 256 of both count bytes and all data bytes; the sync byte is excluded.
REQ-026 The byte accepted in CHECK SHALL be compared with the checksum:
- equal -> DONE;
- unequal -> ERROR.
REQ-027 done SHALL go to 1 in the cycle after the transition into DONE is decided, and cpu_reset_n SHALL go to 1 on the same edge as done.
REQ-028 error SHALL go to 1 on the edge that enters ERROR, and cpu_reset_n SHALL remain 0.
REQ-029 DONE and ERROR SHALL be terminal until reset is asserted.
REQ-030 Words already written before an error SHALL NOT be retracted.
REQ-031 rx_valid low for any number of cycles SHALL stall the block without changing its state.
REQ-032 imem_we SHALL be 0 at all times other than the pulses defined in REQ-021.

Reset
REQ-033 reset=0 SHALL asynchronously force the following, including mid-load:
- state=WAIT_SYNC;
- rx_ready=0 while reset is asserted;
- imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_reset_n=0, done=0, error=0, words_loaded=0;
- checksum, byte counter and word index = 0.
REQ-034 After reset deassertion, rx_ready SHALL be 1 from the first clock edge onward.

Verification
REQ-035 Reset check: assert reset mid-operation -> all outputs take the REQ-033 values immediately, without waiting for a clock edge.
REQ-036 Nominal 2-word load:
- stimulus: bytes 00 FF A5 00 02 20 08 00 05 AC 01 00 00 DC;
- writes: addr 0 = 32'h20080005, then addr 4 = 32'hAC010000, each imem_we a single cycle;
- result: done=1, cpu_reset_n=1, words_loaded=2.
REQ-037 Bad checksum: same stream with final byte DD -> both writes occur, error=1, done=0, cpu_reset_n=0, rx_ready=0.
REQ-038 Empty load: bytes A5 00 00 00 -> no imem_we pulse, done=1, words_loaded=0.
REQ-039 Oversize count: bytes A5 01 01 (257) -> error=1 after the 3rd byte, no writes.
REQ-040 Stall and mid-load reset:
- stimulus: nominal stream with rx_valid deasserted for 3 cycles between bytes, then reset pulsed after the first write;
- required: identical write data under the stall; after the reset pulse, full reset state, and a fresh nominal stream then completes normally.

Source files
------------

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader that receives a framed program image from a host byte
// stream, writes it word by word into instruction memory and then releases
// the processor from reset if the image checksum matches.
//
// Frame: A5 | count_hi | count_lo | count*4 data bytes (big-endian words) | sum
// where sum is the 8-bit modulo-256 sum of the two count bytes and all data
// bytes (the sync byte is not included).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   rx_valid      host byte on rx_data is valid
//   rx_data       host byte
//   rx_ready      loader accepts a byte this cycle
//   imem_we       instruction-memory write strobe (single-cycle pulses)
//   imem_addr     instruction-memory byte address
//   imem_wdata    instruction word to write
//   cpu_reset_n   active-low reset to the processor
//   done          load completed with a good checksum
//   error         load aborted (oversize count or bad checksum)
//   words_loaded  count of words written so far
// -----------------------------------------------------------------------------
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] MAX_COUNT = 32'(MAX_WORDS);

    state_t      state;
    logic [7:0]  count_hi;
    logic [15:0] word_count;
    logic [15:0] word_index;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  checksum;

    logic        accept;
    logic [15:0] rx_count;
    logic [31:0] rx_count_ext;

    assign accept       = rx_valid && rx_ready;
    assign rx_count     = {count_hi, rx_data};
    assign rx_count_ext = {16'd0, rx_count};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= WAIT_SYNC;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= 32'd0;
            imem_wdata   <= 32'd0;
            cpu_reset_n  <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            count_hi     <= 8'd0;
            word_count   <= 16'd0;
            word_index   <= 16'd0;
            byte_cnt     <= 2'd0;
            word_buf     <= 24'd0;
            checksum     <= 8'd0;
        end else begin
            imem_we <= 1'b0;

            // Ready comes up on the first edge after reset and stays up in
            // every non-terminal state; the terminal transitions below
            // override it to 0 on the edge that enters DONE/ERROR.
            if (state != DONE && state != ERROR) begin
                rx_ready <= 1'b1;
            end

            if (accept) begin
                case (state)
                    WAIT_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= CNT_HI;
                        end
                    end

                    CNT_HI: begin
                        count_hi <= rx_data;
                        checksum <= checksum + rx_data;
                        state    <= CNT_LO;
                    end

                    CNT_LO: begin
                        word_count <= rx_count;
                        checksum   <= checksum + rx_data;
                        if (rx_count == 16'd0) begin
                            state <= CHECK;
                        end else if (rx_count_ext > MAX_COUNT) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end

                    DATA: begin
                        checksum <= checksum + rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte completes the word: write it in
                            // the next cycle. word_buf needs no clearing as
                            // the next three bytes overwrite it fully.
                            imem_we      <= 1'b1;
                            imem_addr    <= BASE_ADDR + {14'd0, word_index, 2'b00};
                            imem_wdata   <= {word_buf, rx_data};
                            words_loaded <= words_loaded + 16'd1;
                            word_index   <= word_index + 16'd1;
                            if (word_index + 16'd1 == word_count) begin
                                state <= CHECK;
                            end
                        end else begin
                            word_buf <= {word_buf[15:0], rx_data};
                        end
                    end

                    CHECK: begin
                        rx_ready <= 1'b0;
                        if (rx_data == checksum) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end

                    default: begin
                        // DONE and ERROR hold until reset.
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed testbench for program_loader: reset behaviour, nominal two-word
// load, bad checksum, empty load, count boundary, oversize count, and a
// stalled load interrupted by an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    program_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: records every cycle in which imem_we is high, and counts
    // any back-to-back high cycles (a pulse must last exactly one cycle).
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_total = 0;
    int          multi_total = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr[wr_total % 32] = imem_addr;
            wr_data[wr_total % 32] = imem_wdata;
            wr_total = wr_total + 1;
            if (prev_we === 1'b1) multi_total = multi_total + 1;
        end
        prev_we = (imem_we === 1'b1);
    end

    logic [7:0] nom [14] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08,
                             8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00, 8'hDC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (rx_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (rx_ready !== 1'b1) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},     {31'd0, rx_ready},    32'd0);
        check({tag, "_imem_we"},      {31'd0, imem_we},     32'd0);
        check({tag, "_imem_addr"},    imem_addr,            32'd0);
        check({tag, "_imem_wdata"},   imem_wdata,           32'd0);
        check({tag, "_cpu_reset_n"},  {31'd0, cpu_reset_n}, 32'd0);
        check({tag, "_done"},         {31'd0, done},        32'd0);
        check({tag, "_error"},        {31'd0, error},       32'd0);
        check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int mbase;
        logic [7:0] bad [14];

        // ---------------- power-on reset ----------------
        #3 reset = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // ---------------- nominal 2-word load ----------------
        base = wr_total;
        mbase = multi_total;
        for (int i = 0; i < 14; i++) begin
            send_byte(nom[i]);
            if (i == 8) begin
                check("nom_w0_we",   {31'd0, imem_we}, 32'd1);
                check("nom_w0_addr", imem_addr,        32'h0000_0000);
                check("nom_w0_data", imem_wdata,       32'h2008_0005);
                check("nom_w0_cnt",  {16'd0, words_loaded}, 32'd1);
            end
            if (i == 12) begin
                check("nom_w1_we",   {31'd0, imem_we}, 32'd1);
                check("nom_w1_addr", imem_addr,        32'h0000_0004);
                check("nom_w1_data", imem_wdata,       32'hAC01_0000);
            end
            if (i == 13) begin
                check("nom_done",        {31'd0, done},        32'd1);
                check("nom_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);
                check("nom_rx_ready",    {31'd0, rx_ready},    32'd0);
            end
        end
        idle(4);
        check("nom_writes",     wr_total - base,       32'd2);
        check("nom_wr0_addr",   wr_addr[base % 32],    32'h0000_0000);
        check("nom_wr0_data",   wr_data[base % 32],    32'h2008_0005);
        check("nom_wr1_addr",   wr_addr[(base+1) % 32], 32'h0000_0004);
        check("nom_wr1_data",   wr_data[(base+1) % 32], 32'hAC01_0000);
        check("nom_single_we",  multi_total - mbase,   32'd0);
        check("nom_words",      {16'd0, words_loaded}, 32'd2);
        check("nom_done_hold",  {31'd0, done},         32'd1);
        check("nom_error",      {31'd0, error},        32'd0);
        check("nom_we_idle",    {31'd0, imem_we},      32'd0);

        // ---------------- bad checksum ----------------
        do_reset();
        bad = nom;
        bad[13] = 8'hDD;
        base = wr_total;
        for (int i = 0; i < 14; i++) send_byte(bad[i]);
        check("bad_error_edge", {31'd0, error}, 32'd1);
        idle(3);
        check("bad_writes",      wr_total - base,       32'd2);
        check("bad_wr1_data",    wr_data[(base+1) % 32], 32'hAC01_0000);
        check("bad_error",       {31'd0, error},        32'd1);
        check("bad_done",        {31'd0, done},         32'd0);
        check("bad_cpu_reset_n", {31'd0, cpu_reset_n},  32'd0);
        check("bad_rx_ready",    {31'd0, rx_ready},     32'd0);
        check("bad_words",       {16'd0, words_loaded}, 32'd2);

        // ---------------- empty load ----------------
        do_reset();
        base = wr_total;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(3);
        check("empty_writes", wr_total - base,       32'd0);
        check("empty_done",   {31'd0, done},         32'd1);
        check("empty_cpu",    {31'd0, cpu_reset_n},  32'd1);
        check("empty_words",  {16'd0, words_loaded}, 32'd0);

        // ---------------- count == MAX_WORDS is accepted ----------------
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        check("max_error", {31'd0, error},    32'd0);
        check("max_ready", {31'd0, rx_ready}, 32'd1);

        // ---------------- oversize count ----------------
        do_reset();
        base = wr_total;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check("over_error", {31'd0, error},    32'd1);
        check("over_ready", {31'd0, rx_ready}, 32'd0);
        idle(3);
        check("over_writes", wr_total - base,  32'd0);
        check("over_done",   {31'd0, done},    32'd0);

        // ---------------- stalled load, then mid-load reset ----------------
        do_reset();
        base = wr_total;
        for (int i = 0; i < 10; i++) begin
            send_byte(nom[i]);
            if (i == 8) begin
                check("stall_w0_we",   {31'd0, imem_we}, 32'd1);
                check("stall_w0_addr", imem_addr,        32'h0000_0000);
                check("stall_w0_data", imem_wdata,       32'h2008_0005);
            end
            if (i < 9) idle(3);
        end
        check("stall_writes", wr_total - base, 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        base = wr_total;
        for (int i = 0; i < 14; i++) send_byte(nom[i]);
        idle(3);
        check("fresh_writes",   wr_total - base,        32'd2);
        check("fresh_wr0_data", wr_data[base % 32],     32'h2008_0005);
        check("fresh_wr1_addr", wr_addr[(base+1) % 32], 32'h0000_0004);
        check("fresh_wr1_data", wr_data[(base+1) % 32], 32'hAC01_0000);
        check("fresh_done",     {31'd0, done},          32'd1);
        check("fresh_words",    {16'd0, words_loaded},  32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
